// File: rtl/fredkin_pkg.sv
// rtl/fredkin_pkg.sv - shared FSM state type and rotate-direction constants for the Fredkin rotator
package fredkin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/fredkin_swap_row.sv
// rtl/fredkin_swap_row.sv - one row of Fredkin controlled-swap cells: conditional rotate by DIST
module fredkin_swap_row #(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             control,
    input  logic             dir,
    output logic [WIDTH-1:0] result
);
    import fredkin_pkg::*;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        // Left rotate pulls bit i from i-DIST, right rotate from i+DIST, both wrapping.
        localparam int SRC_L = (i - (DIST % WIDTH) + WIDTH) % WIDTH;
        localparam int SRC_R = (i + DIST) % WIDTH;

        assign result[i] = control ? ((dir == DIR_RIGHT) ? data[SRC_R] : data[SRC_L])
                                   : data[i];
    end

endmodule

// File: rtl/fredkin_rotator_seq.sv
// rtl/fredkin_rotator_seq.sv - multi-cycle rotate unit, one binary-weighted swap row per clock
// Optional conservation check enabled by defining FREDKIN_ROT_CONSERVE_CHECK_EN.
module fredkin_rotator_seq
    import fredkin_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FREDKIN_ROT_CONSERVE_CHECK_EN
    ,
    output logic             out_cons_err
`endif
);

    localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   k;
    logic             dir;
    logic [WIDTH-1:0] row_out [SHW];
    logic [WIDTH-1:0] stage_out;
    logic             last_stage;

    for (genvar g = 0; g < SHW; g++) begin : g_row
        fredkin_swap_row #(
            .WIDTH (WIDTH),
            .DIST  (1 << g)
        ) u_row (
            .data    (work),
            .control (amt[g]),
            .dir     (dir),
            .result  (row_out[g])
        );
    end

    always_comb begin
        stage_out = work;
        for (int s = 0; s < SHW; s++) begin
            if (k == SHW'(s)) stage_out = row_out[s];
        end
    end

    assign last_stage = (state == SHIFT) && (k == K_LAST);
    assign in_ready   = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = SHIFT;
            SHIFT:   if (k == K_LAST) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

`ifdef FREDKIN_ROT_CONSERVE_CHECK_EN
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) cnt = cnt + CW'(v[i]);
        return cnt;
    endfunction

    logic [CW-1:0] pop_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_in       <= '0;
            out_cons_err <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) pop_in <= popcount(in_data);
            if (last_stage)                out_cons_err <= (popcount(stage_out) != pop_in);
            if (state == DONE && out_ready) out_cons_err <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            amt       <= '0;
            k         <= '0;
            dir       <= DIR_LEFT;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        amt  <= in_amt;
                        dir  <= in_dir;
                        k    <= '0;
                    end
                end
                SHIFT: begin
                    work <= stage_out;
                    k    <= k + SHW'(1);
                    if (last_stage) begin
                        out_data  <= stage_out;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fredkin_rotator_seq.sv
// tb/tb_fredkin_rotator_seq.sv - directed and random self-checking bench for fredkin_rotator_seq
module tb_fredkin_rotator_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_amt = '0;
    logic       in_dir = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef FREDKIN_ROT_CONSERVE_CHECK_EN
    logic       out_cons_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fredkin_rotator_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_amt       (in_amt),
        .in_dir       (in_dir),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
`ifdef FREDKIN_ROT_CONSERVE_CHECK_EN
        ,
        .out_cons_err (out_cons_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic [2:0] a, input logic r);
        logic [15:0] dd;
        dd = {d, d};
        if (r) dd = dd >> a;
        else   dd = dd << a;
        return r ? dd[7:0] : dd[15:8];
    endfunction

    // Offer one operand, wait for the result, check it and the latency, then drain it.
    task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] a,
                          input logic r, input logic [7:0] exp);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_amt = a; in_dir = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_data"}, out_data, exp);
`ifdef FREDKIN_ROT_CONSERVE_CHECK_EN
        check({tag, "_cons"}, out_cons_err, 1'b0);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drain"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [7:0] rd;
        logic [2:0] ra;
        logic       rr;
        int         seen;

        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef FREDKIN_ROT_CONSERVE_CHECK_EN
        check("rst_cons_err", out_cons_err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1'b1);

        run_op("rotl1_81", 8'h81, 3'd1, 1'b0, 8'h03);
        run_op("rotr3_b4", 8'hB4, 3'd3, 1'b1, 8'h96);
        run_op("amt0_5a", 8'h5A, 3'd0, 1'b0, 8'h5A);
        run_op("rotr7_01", 8'h01, 3'd7, 1'b1, 8'h02);

        // Stall in DONE with in_valid toggling: nothing may be captured.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h0F; in_amt = 3'd2; in_dir = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_enter_valid", out_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_data = 8'hF0 ^ 8'(c);
            in_amt = 3'd5;
            @(posedge clk); #1;
            check("stall_data", out_data, 8'h3C);
            check("stall_ready", {out_valid, in_ready}, 2'b10);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall_release", {out_valid, in_ready}, 2'b01);
        run_op("after_stall", 8'h01, 3'd7, 1'b0, 8'h80);

        // Reset asserted mid-SHIFT.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd1; in_dir = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 8'h00);
        check("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_valid", seen, 0);

        for (int n = 0; n < 256; n++) begin
            rd = 8'($urandom_range(0, 255));
            ra = 3'($urandom_range(0, 7));
            rr = 1'($urandom_range(0, 1));
            run_op("rand", rd, ra, rr, ref_rot(rd, ra, rr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fredkin_rotator_seq.md
# fredkin_rotator_seq

Multi-cycle rotate unit for the reversible ALU datapath, built from rows of Fredkin controlled-swap cells. It consumes an operand plus a rotate amount and direction, applies one binary-weighted swap stage per clock, and presents the result over a valid/ready handshake. Rotation only permutes bits, so the unit is conservative: the output carries the same number of ones as the input. It sits downstream of the operand-select logic and feeds the ALU result mux.

## Interface
- WIDTH, 8: operand width; power of two, ≥ 2
- SHW, $clog2(WIDTH): rotate-amount width and number of stages; derived, not overridden

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  unit can accept; equals (state == IDLE)
- in_data  in  WIDTH  operand
- in_amt  in  SHW  rotate amount, 0..WIDTH-1
- in_dir  in  1  0 = rotate left, 1 = rotate right
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  rotated result, registered
- out_cons_err  out  1  conservation-check flag; present only with the macro

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data into the work register, and capture amt and dir. Clear stage counter k. Go to SHIFT.
- SHIFT:
  - Each cycle, stage k is applied. If amt[k] = 1, the work register is rotated by 2^k in the direction dir. Otherwise it is unchanged.
  - Per bit i, a Fredkin cell with control = amt[k] selects between bit i and bit (i ∓ 2^k) mod WIDTH.
  - k increments each cycle. After stage SHW-1, out_data is loaded and the FSM goes to DONE.
- DONE:
  - out_valid = 1; out_data holds stable.
  - On out_ready, return to IDLE.
  - in_ready = 0 throughout SHIFT and DONE. in_valid is ignored in those states; no queueing.
- Amount 0 runs all stages with every control at 0, so out_data = in_data. There is no early exit.
- All index arithmetic is modulo WIDTH. Rotation wraps; no bit is lost or zero-filled.
- Reset values:
  - state IDLE, k 0, work register 0, out_data 0, out_valid 0, out_cons_err 0.
  - in_ready reads 1 while in reset, but flops are held, so no capture occurs.
- Reset mid-operation clears everything immediately. The in-flight result is discarded and no out_valid is produced.

## Timing
- Capture edge t0. Stages are applied on edges t1..tSHW. out_valid rises after edge tSHW, i.e. SHW cycles after capture (3 for WIDTH = 8).
- Fastest throughput is one operation per SHW+2 cycles: SHW stages, one DONE cycle with out_ready high, and one IDLE accept cycle.
- out_data and out_valid are flop outputs with no combinational path from inputs. in_ready is decoded from state only.
- out_valid & out_ready in DONE is the transfer. out_valid drops on the next edge.

## Configuration
- Macro: FREDKIN_ROT_CONSERVE_CHECK_EN.
- Defined:
  - The popcount of the captured operand is stored at t0.
  - When loading out_data, out_cons_err is registered as (popcount(result) ≠ stored popcount). It is valid with out_valid and cleared on leaving DONE.
- Undefined: the out_cons_err port, the popcount logic and the stored count are absent. The datapath is otherwise identical.

## Structure
- Package fredkin_pkg:
  - FSM state enum typedef.
  - Constants DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1.
- One sub-module, fredkin_swap_row (parameters WIDTH, DIST):
  - Inputs: control and dir.
  - A row of WIDTH controlled-swap cells producing a conditional rotate by DIST.
- The top generates SHW rows with DIST = 2^k and selects the active row's output by k.

## Test plan
- Reset → out_valid 0, out_data 0x00, in_ready 1, out_cons_err 0; after release, FSM in IDLE.
- WIDTH 8, in_data 0x81, amt 1, left → out_data 0x03, out_valid 3 cycles after capture.
- in_data 0xB4, amt 3, right → out_data 0x96; with the macro, out_cons_err 0.
- in_data 0x5A, amt 0 → out_data 0x5A, latency still 3.
- Hold out_ready low 5 cycles in DONE while toggling in_valid with new data → out_data stable, in_ready 0, no capture; then out_ready 1 → IDLE, next operand accepted.
- Assert rst_n low mid-SHIFT → outputs cleared at once and no out_valid afterward. Follow with 256 random operands cross-checked against a reference rotate, with out_cons_err always 0.
